dct_mac_dsp: RTL and testbench
==============================

// Module: dct_mac_dsp
// PURPOSE
//  Pipelined pre-subtract / multiply / accumulate slice, DSP48-style, for one DCT coefficient of the
//  JPEG component encoder. Each cycle computes (A-D)*B: level-shifted pixel times cos-cos weight.
//  Sums a row of 8 products on top of a partial sum (C) read from the per-MCU accumulator RAM.
//  Carries a control flag through the same latency so the caller knows when P can be stored.
// PARAMETERS
//  AW     9   A/D width, unsigned
//  BW     8   B width, two's complement
//  PW     24  C/P width, two's complement
//  LAT    4   input-to-P latency in cycles (fixed; other values unsupported)
// PORTS
//  clk          in   1   rising-edge clock, single clock domain
//  rst_n        in   1   synchronous, active-low reset
//  load         in   1   first sample of a row: restart accumulation from C
//  clear        in   1   with load: restart from 0 instead of C (first row of block)
//  idelay       in   1   flag delayed to odelay/odelay_pre1 (caller: valid && last column)
//  A            in   9   unsigned pixel ({1'b0,pix})
//  B            in   8   signed coefficient
//  rrC          in   24  signed partial sum, sampled at the P stage (see timing)
//  D            in   9   unsigned pre-subtrahend (caller ties to 128)
//  P            out  24  signed accumulator
//  odelay_pre1  out  1   idelay delayed LAT-1 cycles
//  odelay       out  1   idelay delayed LAT cycles; high exactly while P holds the row result
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all pipeline regs, P, odelay, odelay_pre1 <= 0. Inputs ignored.
//  - Input sampled every cycle; no valid/stall. Caller gates via idelay/odelay only.
//  - Stage 1 (edge t+1): register A, B, D, load, clear, idelay.
//  - Stage 2 (t+2): AD <= $signed({1'b0,A}) - $signed({1'b0,D}), 10-bit signed; range -128..127 for pixels.
//  - Stage 3 (t+3): M <= AD*B, 18-bit signed, exact.
//  - Stage 4 (t+4): if load_d3 && clear_d3:  P <= sext(M)
//                   else if load_d3:         P <= rrC + sext(M)    (rrC as present in cycle t+3)
//                   else:                    P <= P + sext(M)
//    P arithmetic modulo 2^24 (wraps) unless DSP_SAT_EN.
//  - odelay_pre1 = idelay from 3 cycles earlier; odelay = idelay from 4 cycles earlier; both registered.
//  - Row of 8 inputs t..t+7, load at t, idelay at t+7: P valid in cycles t+11.. until the next edge.
//    odelay=1 in exactly that cycle.
//  - Back-to-back rows: next load at t+8 reaches stage 4 at t+12. No bubble or hazard.
//  - clear without load has no effect. Simultaneous load/clear/idelay all legal.
//  - Reset mid-row drops in-flight data. First row after reset needs load.
// CONFIGURATION
//  - DSP_SAT_EN defined: stage-4 add saturates to [-2^23, 2^23-1] instead of wrapping.
//  - DSP_SAT_EN undefined: modulo 2^24.
//  - Latency unchanged either way.
// STRUCTURE
//  - Package dct_mac_pkg: AW/BW/PW/LAT localparams, AD width 10, M width 18.
//  - Sub-module dct_mac_delay (N-stage flag shift register, sync active-low reset) generates
//    load_d3/clear_d3 and odelay_pre1/odelay.
//  - Datapath inline; infers one DSP slice.
// TESTING
//  - Reset: rst_n=0 two cycles with random inputs -> P=0, odelay=0, odelay_pre1=0.
//  - Single row: D=128, A=255 x8, B=1, load+clear on 1st, idelay on 8th -> P=1016.
//    odelay high 4 cycles after idelay, odelay_pre1 one cycle before.
//  - Chained row: load (no clear) with rrC=1000, A=0 x8, B=-1 -> P=1000+8*128=2024 when odelay=1.
//  - Negative: A=0, B=-128, D=128 x8 with load+clear -> P=131072. A=255, B=-128 -> P=-130048.
//  - Back-to-back rows with load at t and t+8: two distinct correct results 8 cycles apart.
//    No cross-contamination.
//  - Overflow, rrC=2^23-100, positive products: wraps negative (no macro) / holds 8388607 (DSP_SAT_EN).

Source files
------------

// File: rtl/dct_mac_pkg.sv
// dct_mac shared widths and the stage-4 adder.
// DSP_SAT_EN: stage-4 add saturates instead of wrapping.
package dct_mac_pkg;

  localparam int AW  = 9;
  localparam int BW  = 8;
  localparam int PW  = 24;
  localparam int LAT = 4;
  localparam int ADW = 10;
  localparam int MW  = 18;

  function automatic logic signed [PW-1:0] p_add(
    input logic signed [PW-1:0] x,
    input logic signed [PW-1:0] y
  );
    logic [PW:0] s;
    s = {x[PW-1], x} + {y[PW-1], y};
`ifdef DSP_SAT_EN
    // top two bits disagree only on overflow
    if (s[PW] != s[PW-1])
      return s[PW] ? {1'b1, {(PW-1){1'b0}}}
                   : {1'b0, {(PW-1){1'b1}}};
`endif
    return s[PW-1:0];
  endfunction

endpackage

// File: rtl/dct_mac_delay.sv
// dct_mac_delay: N-stage flag shift register, sync active-low reset.
// Ports: clk, rst_n, d[W] in, q[W] = d delayed N cycles.
module dct_mac_delay #(
  parameter int N = 3,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/dct_mac_dsp.sv
// dct_mac_dsp: 4-stage (A-D)*B accumulate slice for one DCT coefficient.
// Ports: clk, rst_n (sync, low), load, clear, idelay, A, B, rrC, D in;
//   P, odelay_pre1, odelay out. DSP_SAT_EN: saturating P adder.
module dct_mac_dsp
  import dct_mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 idelay,
  input  logic [AW-1:0]        A,
  input  logic signed [BW-1:0] B,
  input  logic signed [PW-1:0] rrC,
  input  logic [AW-1:0]        D,
  output logic signed [PW-1:0] P,
  output logic                 odelay_pre1,
  output logic                 odelay
);

  logic                  load_d3;
  logic                  clear_d3;
  logic [AW-1:0]         a_q;
  logic [AW-1:0]         d_q;
  logic signed [BW-1:0]  b_q;
  logic signed [BW-1:0]  b_q2;
  logic signed [ADW-1:0] ad_q;
  logic signed [MW-1:0]  m_q;
  logic signed [PW-1:0]  m_ext;
  logic signed [PW-1:0]  base;
  logic signed [PW-1:0]  p_nxt;

  dct_mac_delay #(.N(3), .W(3)) u_ctl (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({load, clear, idelay}),
    .q     ({load_d3, clear_d3, odelay_pre1})
  );

  dct_mac_delay #(.N(1), .W(1)) u_od (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (odelay_pre1),
    .q     (odelay)
  );

  assign m_ext = {{(PW-MW){m_q[MW-1]}}, m_q};

  // load+clear starts from zero, load alone from rrC
  always_comb begin
    base = P;
    if (load_d3)
      base = clear_d3 ? '0 : rrC;
    p_nxt = p_add(base, m_ext);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      d_q  <= '0;
      b_q  <= '0;
      b_q2 <= '0;
      ad_q <= '0;
      m_q  <= '0;
      P    <= '0;
    end else begin
      a_q  <= A;
      d_q  <= D;
      b_q  <= B;
      ad_q <= $signed({1'b0, a_q}) - $signed({1'b0, d_q});
      b_q2 <= b_q;
      m_q  <= ad_q * b_q2;
      P    <= p_nxt;
    end
  end

endmodule

// File: tb/tb_dct_mac_dsp.sv
// tb_dct_mac_dsp: random + directed check of dct_mac_dsp
// against a cycle-indexed arithmetic model.
module tb_dct_mac_dsp;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load, clear, idelay;
  logic [8:0]         A, D;
  logic signed [7:0]  B;
  logic signed [23:0] rrC;
  logic signed [23:0] P;
  logic               odelay_pre1, odelay;

  dct_mac_dsp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .clear       (clear),
    .idelay      (idelay),
    .A           (A),
    .B           (B),
    .rrC         (rrC),
    .D           (D),
    .P           (P),
    .odelay_pre1 (odelay_pre1),
    .odelay      (odelay)
  );

  always #5 clk = ~clk;

  localparam int HN = 2048;

  int  a_h [HN];
  int  b_h [HN];
  int  d_h [HN];
  int  rc_h[HN];
  bit  ld_h[HN];
  bit  cl_h[HN];
  bit  id_h[HN];
  bit  rs_h[HN];

  typedef struct {
    int    cyc;
    int    val;
    string tag;
  } exp_t;
  exp_t dq[$];

  int     c = 0;
  int     n_chk = 0;
  int     n_err = 0;
  longint pm = 0;
  bit     armed = 0;

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, c, got, exp);
    end
  endtask

  function automatic longint fix(longint v);
`ifdef DSP_SAT_EN
    if (v > 8388607)  return 8388607;
    if (v < -8388608) return -8388608;
    return v;
`else
    longint w;
    w = v & 64'hFFFFFF;
    if (w >= 8388608) w -= 16777216;
    return w;
`endif
  endfunction

  // input from cycle i survives to edge e if no reset edge in between
  function automatic bit clean(int i, int e);
    if (i < 0) return 0;
    for (int k = i; k < e; k++)
      if (!rs_h[k]) return 0;
    return 1;
  endfunction

  task automatic tick();
    longint m;
    bit     od_m, op_m;
    a_h[c]  = int'(A);
    b_h[c]  = int'(B);
    d_h[c]  = int'(D);
    rc_h[c] = int'(rrC);
    ld_h[c] = load;
    cl_h[c] = clear;
    id_h[c] = idelay;
    rs_h[c] = rst_n;
    @(posedge clk);
    #1;
    c++;
    if (!rs_h[c-1]) begin
      pm    = 0;
      armed = 1;
    end else if (clean(c-4, c)) begin
      m = longint'((a_h[c-4] - d_h[c-4]) * b_h[c-4]);
      if (ld_h[c-4] && cl_h[c-4])
        pm = m;
      else if (ld_h[c-4])
        pm = fix(longint'(rc_h[c-1]) + m);
      else
        pm = fix(pm + m);
    end
    od_m = clean(c-4, c) ? id_h[c-4] : 1'b0;
    op_m = clean(c-3, c) ? id_h[c-3] : 1'b0;
    if (armed) begin
      check("P", longint'(P), pm);
      check("odelay", longint'(odelay), longint'(od_m));
      check("odelay_pre1", longint'(odelay_pre1),
            longint'(op_m));
    end
    if (dq.size() > 0 && dq[0].cyc == c) begin
      check(dq[0].tag, longint'(P), longint'(dq[0].val));
      check({dq[0].tag, "_od"}, longint'(odelay), 1);
      void'(dq.pop_front());
    end
  endtask

  task automatic rnd_in();
    A   = 9'($urandom_range(0, 511));
    D   = 9'($urandom_range(0, 511));
    B   = 8'($urandom);
    rrC = 24'($urandom);
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) begin
      rnd_in();
      load   = 1'b0;
      clear  = 1'b0;
      idelay = 1'b0;
      tick();
    end
  endtask

  task automatic row(string tag, int a, int b, int d,
                     bit ld, bit cl, int rc, int ev);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      A      = 9'(a);
      B      = 8'(b);
      D      = 9'(d);
      rrC    = 24'(rc);
      load   = ld && (j == 0);
      clear  = cl && (j == 0);
      idelay = (j == 7);
      if (j == 7) begin
        e.cyc = c + 4;
        e.val = ev;
        e.tag = tag;
        dq.push_back(e);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rnd_in();
    load   = 1'($urandom);
    clear  = 1'($urandom);
    idelay = 1'($urandom);
    tick();
    rnd_in();
    load   = 1'($urandom);
    idelay = 1'($urandom);
    tick();
    check("rst_P", longint'(P), 0);
    check("rst_od", longint'(odelay), 0);
    check("rst_pre1", longint'(odelay_pre1), 0);
    rst_n = 1'b1;
    idle(2);

    row("single", 255, 1, 128, 1, 1, 0, 1016);
    row("chain", 0, -1, 128, 1, 0, 1000, 2024);
    row("neg0", 0, -128, 128, 1, 1, 77, 131072);
    row("neg255", 255, -128, 128, 1, 1, 77, -130048);
    idle(3);
    row("b2b_a", 200, 3, 128, 1, 1, 0, 1728);
    row("b2b_b", 50, -5, 128, 1, 1, 0, 3120);
`ifdef DSP_SAT_EN
    row("ovf", 255, 127, 128, 1, 0, 8388508, 8388607);
`else
    row("ovf", 255, 127, 128, 1, 0, 8388508, -8259676);
`endif
    idle(6);

    for (int k = 0; k < 400; k++) begin
      rnd_in();
      load   = ($urandom_range(0, 5) == 0);
      clear  = 1'($urandom);
      idelay = ($urandom_range(0, 3) == 0);
      rst_n  = !(k == 200 || k == 201);
      tick();
    end
    rst_n = 1'b1;
    idle(6);

    if (dq.size() != 0)
      check("pending", longint'(dq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
